// File: rtl/tone_sequencer_pkg.sv
// Shared definitions for the tone sequencer and other note players.
// Holds the sequencer state encoding, the note frequency constants
// (C4..C6, in Hz) and the SILENCE value. It also holds the index ->
// frequency lookup used by tone_rom.
package tone_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } seq_state_e;

    localparam logic [31:0] NOTE_C4 = 32'd262;
    localparam logic [31:0] NOTE_D4 = 32'd294;
    localparam logic [31:0] NOTE_E4 = 32'd330;
    localparam logic [31:0] NOTE_F4 = 32'd349;
    localparam logic [31:0] NOTE_G4 = 32'd392;
    localparam logic [31:0] NOTE_A4 = 32'd440;
    localparam logic [31:0] NOTE_B4 = 32'd494;
    localparam logic [31:0] NOTE_C5 = 32'd523;
    localparam logic [31:0] NOTE_D5 = 32'd587;
    localparam logic [31:0] NOTE_E5 = 32'd659;
    localparam logic [31:0] NOTE_F5 = 32'd698;
    localparam logic [31:0] NOTE_G5 = 32'd784;
    localparam logic [31:0] NOTE_A5 = 32'd880;
    localparam logic [31:0] NOTE_B5 = 32'd988;
    localparam logic [31:0] NOTE_C6 = 32'd1047;

    // SILENCE is above the audible range, so PWM_gen produces no audible tone.
    localparam logic [31:0] SILENCE = 32'd20000;

    // Scale lookup. Any index past the last note returns SILENCE.
    function automatic logic [31:0] note_freq(input logic [7:0] idx);
        logic [31:0] f;
        case (idx)
            8'd0:    f = NOTE_C4;
            8'd1:    f = NOTE_D4;
            8'd2:    f = NOTE_E4;
            8'd3:    f = NOTE_F4;
            8'd4:    f = NOTE_G4;
            8'd5:    f = NOTE_A4;
            8'd6:    f = NOTE_B4;
            8'd7:    f = NOTE_C5;
            8'd8:    f = NOTE_D5;
            8'd9:    f = NOTE_E5;
            8'd10:   f = NOTE_F5;
            8'd11:   f = NOTE_G5;
            8'd12:   f = NOTE_A5;
            8'd13:   f = NOTE_B5;
            8'd14:   f = NOTE_C6;
            default: f = SILENCE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/tone_sequencer_rom.sv
// tone_rom: combinational note index -> tone frequency lookup.
// Other players reuse this module.
// Ports:
//   idx  in  8  : note index (0 = C4 ... 14 = C6, larger values give SILENCE)
//   freq out 32 : tone frequency in Hz
module tone_rom
    import tone_sequencer_pkg::*;
(
    input  logic [7:0]  idx,
    output logic [31:0] freq
);

    // Table lookup through the shared package function.
    always_comb begin
        freq = note_freq(idx);
    end

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: beat-driven note sequencer feeding PWM_gen.
// Everything runs on one clock. A free-running beat counter acts as a
// clock enable, so no derived beat clock is needed.
// Ports:
//   clk          in  1  : system clock, all logic on posedge
//   rst          in  1  : synchronous active-high reset
//   cmd_play     in  1  : pulse, enter/resume PLAY
//   cmd_pause    in  1  : pulse, enter PAUSE
//   cmd_up       in  1  : pulse, direction ascending
//   cmd_down     in  1  : pulse, direction descending
//   cmd_speed    in  1  : pulse, toggle slow/fast beat
//   cmd_restart  in  1  : pulse, index 0, ascending, slow, PLAY
//   freq         out 32 : tone frequency (Hz), SILENCE when not playing
//   ibeat        out 8  : current note index
//   beat_tick    out 1  : one-cycle pulse per beat
//   playing      out 1  : high in PLAY
//   at_end       out 1  : index held at a scale end (LOOP=0 only)
module tone_sequencer
    import tone_sequencer_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned BEAT_DIV_SLOW = CLK_HZ,
    parameter int unsigned BEAT_DIV_FAST = CLK_HZ / 2,
    parameter int unsigned NUM_NOTES     = 15,
    parameter int unsigned LOOP          = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_play,
    input  logic        cmd_pause,
    input  logic        cmd_up,
    input  logic        cmd_down,
    input  logic        cmd_speed,
    input  logic        cmd_restart,
    output logic [31:0] freq,
    output logic [7:0]  ibeat,
    output logic        beat_tick,
    output logic        playing,
    output logic        at_end
);

    localparam logic [31:0] DIV_SLOW = 32'(BEAT_DIV_SLOW);
    localparam logic [31:0] DIV_FAST = 32'(BEAT_DIV_FAST);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_NOTES - 1);
    localparam logic        LOOP_EN  = (LOOP != 0);

    seq_state_e  state_r;
    seq_state_e  state_s;
    logic        dir_desc_r;
    logic        dir_desc_s;
    logic        dir_change_s;
    logic        fast_r;
    logic [31:0] cnt_r;
    logic [31:0] div_s;
    logic        cnt_wrap_s;
    logic        beat_tick_r;
    logic [7:0]  ibeat_r;
    logic [7:0]  ibeat_step_s;
    logic        at_end_r;
    logic        at_end_step_s;
    logic        playing_r;
    logic [31:0] freq_r;
    logic [31:0] rom_freq_s;

    tone_rom u_tone_rom (
        .idx  (ibeat_r),
        .freq (rom_freq_s)
    );

    // Next-state logic. Priority is restart > pause > play, so a
    // pause in the same cycle as play blocks play.
    always_comb begin
        state_s = state_r;
        if (cmd_restart) begin
            state_s = ST_PLAY;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_pause) begin
                        state_s = ST_IDLE;
                    end else if (cmd_play) begin
                        state_s = ST_PLAY;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (cmd_pause) begin
                        state_s = ST_PAUSE;
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
                ST_PAUSE: begin
                    if (cmd_pause) begin
                        state_s = ST_PAUSE;
                    end else if (cmd_play) begin
                        state_s = ST_PLAY;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Direction decode. Up and down together cancel and keep the current direction.
    always_comb begin
        dir_desc_s = dir_desc_r;
        if (cmd_up && !cmd_down) begin
            dir_desc_s = 1'b0;
        end else if (cmd_down && !cmd_up) begin
            dir_desc_s = 1'b1;
        end else begin
            dir_desc_s = dir_desc_r;
        end
        dir_change_s = (dir_desc_s != dir_desc_r);
    end

    // Beat divider selection and terminal-count detect. The counter only wraps in PLAY.
    always_comb begin
        div_s      = fast_r ? DIV_FAST : DIV_SLOW;
        cnt_wrap_s = (state_r == ST_PLAY) && (cnt_r == (div_s - 32'd1));
    end

    // Index step for one beat. This always uses the registered
    // direction, so a direction pulse in the tick cycle takes effect
    // on the following beat.
    always_comb begin
        ibeat_step_s  = ibeat_r;
        at_end_step_s = at_end_r;
        if (dir_desc_r) begin
            if (ibeat_r > 8'd0) begin
                ibeat_step_s  = ibeat_r - 8'd1;
                at_end_step_s = 1'b0;
            end else if (LOOP_EN) begin
                ibeat_step_s  = LAST_IDX;
                at_end_step_s = 1'b0;
            end else begin
                ibeat_step_s  = ibeat_r;
                at_end_step_s = 1'b1;
            end
        end else begin
            if (ibeat_r < LAST_IDX) begin
                ibeat_step_s  = ibeat_r + 8'd1;
                at_end_step_s = 1'b0;
            end else if (LOOP_EN) begin
                ibeat_step_s  = 8'd0;
                at_end_step_s = 1'b0;
            end else begin
                ibeat_step_s  = ibeat_r;
                at_end_step_s = 1'b1;
            end
        end
    end

    // Direction and speed registers. Restart forces ascending/slow and masks cmd_speed.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_desc_r <= 1'b0;
            fast_r     <= 1'b0;
        end else if (cmd_restart) begin
            dir_desc_r <= 1'b0;
            fast_r     <= 1'b0;
        end else begin
            dir_desc_r <= dir_desc_s;
            fast_r     <= fast_r ^ cmd_speed;
        end
    end

    // Beat counter and tick. The counter is frozen in PAUSE, so a
    // pause stretches the current beat by its length. A speed change
    // restarts the beat from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= 32'd0;
            beat_tick_r <= 1'b0;
        end else if (cmd_restart || cmd_speed) begin
            cnt_r       <= 32'd0;
            beat_tick_r <= 1'b0;
        end else if (cnt_wrap_s) begin
            cnt_r       <= 32'd0;
            beat_tick_r <= 1'b1;
        end else if (state_r == ST_PLAY) begin
            cnt_r       <= cnt_r + 32'd1;
            beat_tick_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            cnt_r       <= 32'd0;
            beat_tick_r <= 1'b0;
        end else begin
            cnt_r       <= cnt_r;
            beat_tick_r <= 1'b0;
        end
    end

    // Note index and end flag. The index moves on the edge after
    // beat_tick. Turning around clears the end flag, even when a
    // beat lands in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ibeat_r  <= 8'd0;
            at_end_r <= 1'b0;
        end else if (cmd_restart) begin
            ibeat_r  <= 8'd0;
            at_end_r <= 1'b0;
        end else if (beat_tick_r) begin
            ibeat_r  <= ibeat_step_s;
            at_end_r <= dir_change_s ? 1'b0 : at_end_step_s;
        end else if (dir_change_s) begin
            ibeat_r  <= ibeat_r;
            at_end_r <= 1'b0;
        end else begin
            ibeat_r  <= ibeat_r;
            at_end_r <= at_end_r;
        end
    end

    // Registered status and tone outputs. freq tracks the current
    // state register, so silence lags a pause by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            playing_r <= 1'b0;
            freq_r    <= SILENCE;
        end else begin
            playing_r <= (state_s == ST_PLAY);
            freq_r    <= (state_r == ST_PLAY) ? rom_freq_s : SILENCE;
        end
    end

    assign freq      = freq_r;
    assign ibeat     = ibeat_r;
    assign beat_tick = beat_tick_r;
    assign playing   = playing_r;
    assign at_end    = at_end_r;

endmodule
